// File: rtl/launch_pkg.sv
// Shared encodings and defaults for the slingshot launch sequencer.
package launch_pkg;

  // Per-bird sequencing states; the encoding is visible on bird_state.
  typedef enum logic [1:0] {
    WaitForLoad = 2'd0,
    LoadingAnim = 2'd1,
    WaitForShot = 2'd2,
    Flying      = 2'd3
  } bird_state_e;

  // Main-bird selector values; NONE means every bird has been flown.
  localparam logic [2:0] MacroBird0 = 3'd0;
  localparam logic [2:0] MacroBird1 = 3'd1;
  localparam logic [2:0] MacroBird2 = 3'd2;
  localparam logic [2:0] MacroNone  = 3'd7;

  localparam int unsigned DeltaMaxDefault = 63;

  // Selector value after the current bird finishes flying.
  function automatic logic [2:0] next_macro(input logic [2:0] cur, input int unsigned num_birds);
    if ({29'd0, cur} + 32'd1 >= num_birds) begin
      return MacroNone;
    end
    return cur + 3'd1;
  endfunction

endpackage

// File: rtl/aim_axis.sv
// One signed aim axis: saturating +/-1 steps per tick, cleared and captured on launch.
module aim_axis
  import launch_pkg::*;
#(
  parameter int unsigned DW        = 17,
  parameter int unsigned DELTA_MAX = DeltaMaxDefault
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 active,
  input  logic                 capture,
  input  logic                 dec,
  input  logic                 inc,
  output logic signed [DW-1:0] value,
  output logic signed [DW-1:0] captured
);

  localparam logic signed [DW-1:0] MaxPos = $signed(DW'(DELTA_MAX));
  localparam logic signed [DW-1:0] MaxNeg = -MaxPos;
  localparam logic signed [DW-1:0] One    = $signed(DW'(1));

  logic signed [DW-1:0] value_q, value_d;
  logic signed [DW-1:0] captured_q, captured_d;
  logic signed [DW-1:0] step;

  // Next value: capture beats key input; out-of-range steps are dropped.
  always_comb begin
    value_d    = value_q;
    captured_d = captured_q;
    step       = value_q;
    if (inc && !dec) begin
      step = value_q + One;
    end else if (dec && !inc) begin
      step = value_q - One;
    end
    if (tick) begin
      if (capture) begin
        captured_d = value_q;
        value_d    = '0;
      end else if (active) begin
        if (step <= MaxPos && step >= MaxNeg) begin
          value_d = step;
        end
      end else begin
        value_d = '0;
      end
    end
  end

  // Axis registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q    <= '0;
      captured_q <= '0;
    end else begin
      value_q    <= value_d;
      captured_q <= captured_d;
    end
  end

  assign value    = value_q;
  assign captured = captured_q;

endmodule

// File: rtl/launch_controller.sv
// Frame-rate sequencer for the slingshot: bird selector, load/aim/fly FSM, launch pulse.
module launch_controller
  import launch_pkg::*;
#(
  parameter int unsigned NUM_BIRDS   = 3,
  parameter int unsigned LOAD_FRAMES = 31,
  parameter int unsigned FLY_FRAMES  = 480,
  parameter int unsigned DELTA_MAX   = DeltaMaxDefault,
  parameter int unsigned DW          = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 key_w,
  input  logic                 key_a,
  input  logic                 key_s,
  input  logic                 key_d,
  input  logic                 key_space,
  output logic [2:0]           macro_state,
  output logic [1:0]           bird_state,
  output logic [9:0]           cnt,
  output logic signed [DW-1:0] aim_dx,
  output logic signed [DW-1:0] aim_dy,
  output logic signed [DW-1:0] launch_dx,
  output logic signed [DW-1:0] launch_dy,
  output logic                 launch,
  output logic                 birds_done
);

  localparam logic [9:0] LoadLast = 10'(LOAD_FRAMES);
  localparam logic [9:0] FlyLast  = 10'(FLY_FRAMES);

  bird_state_e state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [2:0]  macro_q, macro_d;
  logic        space_prev_q, space_prev_d;
  logic        launch_q, launch_d;
  logic        done;
  logic        space_edge;
  logic        fire;
  logic        aiming;

  assign done       = (macro_q == MacroNone);
  assign space_edge = key_space & ~space_prev_q;
  assign aiming     = (state_q == WaitForShot);
  assign fire       = frame_tick & aiming & space_edge;

  // State register plus the counters that move with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WaitForLoad;
      cnt_q        <= '0;
      macro_q      <= MacroBird0;
      space_prev_q <= 1'b0;
      launch_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      macro_q      <= macro_d;
      space_prev_q <= space_prev_d;
      launch_q     <= launch_d;
    end
  end

  // Next state; nothing moves without a frame tick, and cnt clears on every state exit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    macro_d      = macro_q;
    space_prev_d = space_prev_q;
    launch_d     = 1'b0;
    if (frame_tick) begin
      space_prev_d = key_space;
      cnt_d        = '0;
      case (state_q)
        WaitForLoad: begin
          if (!done) state_d = LoadingAnim;
        end
        LoadingAnim: begin
          if (cnt_q >= LoadLast) state_d = WaitForShot;
          else                   cnt_d   = cnt_q + 10'd1;
        end
        WaitForShot: begin
          if (space_edge) begin
            state_d  = Flying;
            launch_d = 1'b1;
          end
        end
        Flying: begin
          if (cnt_q >= FlyLast) begin
            state_d = WaitForLoad;
            macro_d = next_macro(macro_q, NUM_BIRDS);
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        default: state_d = WaitForLoad;
      endcase
    end
  end

  // Outputs are straight register views.
  always_comb begin
    bird_state  = state_q;
    cnt         = cnt_q;
    macro_state = macro_q;
    launch      = launch_q;
    birds_done  = done;
  end

  aim_axis #(
    .DW       (DW),
    .DELTA_MAX(DELTA_MAX)
  ) u_aim_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (frame_tick),
    .active  (aiming),
    .capture (fire),
    .dec     (key_a),
    .inc     (key_d),
    .value   (aim_dx),
    .captured(launch_dx)
  );

  aim_axis #(
    .DW       (DW),
    .DELTA_MAX(DELTA_MAX)
  ) u_aim_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (frame_tick),
    .active  (aiming),
    .capture (fire),
    .dec     (key_w),
    .inc     (key_s),
    .value   (aim_dy),
    .captured(launch_dy)
  );

endmodule

// File: tb/tb_launch_controller.sv
// Directed bench for launch_controller with hand-computed expectations.
module tb_launch_controller;

  localparam int DW = 17;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 frame_tick = 1'b0;
  logic                 key_w = 1'b0, key_a = 1'b0, key_s = 1'b0, key_d = 1'b0;
  logic                 key_space = 1'b0;
  logic [2:0]           macro_state;
  logic [1:0]           bird_state;
  logic [9:0]           cnt;
  logic signed [DW-1:0] aim_dx, aim_dy, launch_dx, launch_dy;
  logic                 launch;
  logic                 birds_done;

  int total = 0;
  int bad   = 0;

  launch_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .key_w      (key_w),
    .key_a      (key_a),
    .key_s      (key_s),
    .key_d      (key_d),
    .key_space  (key_space),
    .macro_state(macro_state),
    .bird_state (bird_state),
    .cnt        (cnt),
    .aim_dx     (aim_dx),
    .aim_dy     (aim_dy),
    .launch_dx  (launch_dx),
    .launch_dy  (launch_dy),
    .launch     (launch),
    .birds_done (birds_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // n frame ticks; returns on the falling edge after the last tick's clock edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_bs"}, bird_state, 0);
    check({tag, "_cnt"}, cnt, 0);
    check({tag, "_macro"}, macro_state, 0);
    check({tag, "_done"}, birds_done, 0);
    check({tag, "_dx"}, $signed(aim_dx), 0);
    check({tag, "_dy"}, $signed(aim_dy), 0);
    check({tag, "_ldx"}, $signed(launch_dx), 0);
    check({tag, "_ldy"}, $signed(launch_dy), 0);
    check({tag, "_launch"}, launch, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Load animation timing
    tick(1);
    check("load_bs", bird_state, 1);
    check("load_cnt0", cnt, 0);
    tick(31);
    check("load_cnt31", cnt, 31);
    check("load_bs31", bird_state, 1);
    tick(1);
    check("wfs_bs", bird_state, 2);
    check("wfs_cnt", cnt, 0);

    // No tick: everything holds
    repeat (4) @(negedge clk);
    check("idle_bs", bird_state, 2);
    check("idle_launch", launch, 0);

    // Saturation on both axes
    key_d = 1'b1; key_w = 1'b1;
    tick(70);
    check("sat_dx", $signed(aim_dx), 63);
    check("sat_dy", $signed(aim_dy), -63);
    key_w = 1'b0; key_a = 1'b1;
    tick(3);
    check("ad_dx", $signed(aim_dx), 63);
    check("ad_dy", $signed(aim_dy), -63);
    key_d = 1'b0;
    tick(58);
    key_a = 1'b0; key_s = 1'b1;
    tick(60);
    key_s = 1'b0;
    check("pre_dx", $signed(aim_dx), 5);
    check("pre_dy", $signed(aim_dy), -3);

    // Launch with S on the same tick
    key_space = 1'b1; key_s = 1'b1;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check("l0_pulse", launch, 1);
    check("l0_bs", bird_state, 3);
    check("l0_cnt", cnt, 0);
    check("l0_ldx", $signed(launch_dx), 5);
    check("l0_ldy", $signed(launch_dy), -3);
    check("l0_dx", $signed(aim_dx), 0);
    check("l0_dy", $signed(aim_dy), 0);
    @(negedge clk);
    check("l0_pulse_end", launch, 0);
    key_s = 1'b0;

    // Flight of bird 0
    tick(480);
    check("f0_cnt480", cnt, 480);
    check("f0_bs", bird_state, 3);
    check("f0_macro", macro_state, 0);
    key_space = 1'b0;
    tick(1);
    check("f0_exit_bs", bird_state, 0);
    check("f0_exit_macro", macro_state, 1);
    check("f0_exit_cnt", cnt, 0);
    check("f0_ldx_hold", $signed(launch_dx), 5);

    // Bird 1: space held through entry to WAIT_FOR_SHOT
    key_space = 1'b1;
    tick(1);
    check("b1_load", bird_state, 1);
    tick(32);
    check("b1_wfs", bird_state, 2);
    tick(5);
    check("b1_held_bs", bird_state, 2);
    check("b1_held_launch", launch, 0);
    key_space = 1'b0;
    tick(1);
    check("b1_release_bs", bird_state, 2);
    key_space = 1'b1;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check("b1_pulse", launch, 1);
    check("b1_bs", bird_state, 3);
    check("b1_ldx", $signed(launch_dx), 0);
    key_space = 1'b0;
    tick(481);
    check("b1_exit_macro", macro_state, 2);
    check("b1_exit_bs", bird_state, 0);

    // Bird 2, then selector latches NONE
    tick(33);
    check("b2_wfs", bird_state, 2);
    key_space = 1'b1;
    tick(1);
    check("b2_bs", bird_state, 3);
    key_space = 1'b0;
    tick(481);
    check("b2_macro", macro_state, 7);
    check("b2_done", birds_done, 1);
    check("b2_bs", bird_state, 0);
    tick(3);
    check("none_bs", bird_state, 0);
    check("none_macro", macro_state, 7);
    check("none_cnt", cnt, 0);

    // Reset, restart, reset mid-flight
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("rst1_macro", macro_state, 0);
    check("rst1_done", birds_done, 0);
    tick(33);
    key_d = 1'b1;
    tick(2);
    key_d = 1'b0;
    key_space = 1'b1;
    tick(1);
    check("r_ldx", $signed(launch_dx), 2);
    tick(200);
    check("r_cnt200", cnt, 200);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    frame_tick = 1'b1;
    repeat (3) @(negedge clk);
    frame_tick = 1'b0;
    check("midrst_launch", launch, 0);
    key_space = 1'b0;
    rst_n = 1'b1;
    tick(1);
    check("restart_bs", bird_state, 1);
    check("restart_cnt", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/launch_controller.md
Name: launch_controller

Overview:
- Per-frame sequencer for the slingshot stage; sits directly upstream of the bird address/physics generators.
- Owns the main-bird selector (macro state), the per-bird load/aim/fly FSM, the frame counter that drives load and flight animation, WASD aim offsets and the launch pulse.
- Advances only on the one-cycle frame tick derived from vsync. Consumes raw key levels from the keyboard decoder.

Parameters:
- NUM_BIRDS, 3, birds available per level (1..6).
- LOAD_FRAMES, 31, last counter value in LOADING_ANIM; the state lasts LOAD_FRAMES+1 ticks.
- FLY_FRAMES, 480, last counter value in FLYING; 8 s at 60 Hz.
- DELTA_MAX, 63, magnitude limit on each aim axis.
- DW, 17, width of the signed aim outputs.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame (falling edge of vsync); all state updates happen only on it.
- key_w, key_a, key_s, key_d  in  1 each  key-held levels.
- key_space  in  1  space-held level.
- macro_state  out  3  index of the main bird; 7 = NONE (all birds used).
- bird_state  out  2  0 WAIT_FOR_LOAD, 1 LOADING_ANIM, 2 WAIT_FOR_SHOT, 3 FLYING.
- cnt  out  10  animation counter.
- aim_dx, aim_dy  out  DW  signed live aim offset.
- launch_dx, launch_dy  out  DW  signed offset captured at launch.
- launch  out  1  one-clk pulse on entry to FLYING.
- birds_done  out  1  high while macro_state == NONE.

Behaviour:
- Reset is async on rst_n low. All outputs go to 0 except macro_state = 0 and birds_done = 0. The internal space_prev register also clears to 0.
- Between ticks, every register holds. When no frame_tick arrives, no output changes, and launch is 0.
- Space edge: space_edge = key_space & ~space_prev, evaluated on a tick. space_prev <= key_space on every tick. A press and release that both fall between two ticks is not seen.
- bird_state transitions, evaluated on each tick:
  - WAIT_FOR_LOAD -> LOADING_ANIM, unless birds_done; then it stays put.
  - LOADING_ANIM -> WAIT_FOR_SHOT when cnt >= LOAD_FRAMES.
  - WAIT_FOR_SHOT -> FLYING on space_edge.
  - FLYING -> WAIT_FOR_LOAD when cnt >= FLY_FRAMES.
- cnt on a tick:
  - cnt+1 while in LOADING_ANIM or FLYING, excluding the tick that leaves the state.
  - Otherwise cleared to 0.
  - The tick that enters LOADING_ANIM or FLYING leaves cnt at 0. cnt therefore spans 0..LOAD_FRAMES and 0..FLY_FRAMES, and never wraps.
- macro_state:
  - Increments on the same tick as the FLYING -> WAIT_FOR_LOAD transition, and only then.
  - After index NUM_BIRDS-1 it becomes 7 (NONE) and latches until reset.
- Aim, while in WAIT_FOR_SHOT, on a tick:
  - dy: W gives -1, S gives +1; both or neither give no change.
  - dx: A gives -1, D gives +1; both or neither give no change.
  - Each axis saturates independently: an update that would make |value| > DELTA_MAX is discarded for that axis only.
- On the launch tick:
  - launch_dx/launch_dy <= aim_dx/aim_dy as they were before the tick; keys on that tick are ignored.
  - aim_dx/aim_dy <= 0.
- In every other state aim_dx/aim_dy are forced to 0. launch_dx/launch_dy hold until the next launch.
- launch is high for exactly one clk, the cycle after the launching tick, coincident with bird_state first reading 3.
- Simultaneous events: space_edge together with aim keys means launch wins. Space in any state other than WAIT_FOR_SHOT is ignored, but space_prev still tracks it.
- Mid-operation reset returns everything to reset values immediately; no partial launch pulse is emitted.

Decomposition:
- Shared package launch_pkg holds:
  - bird_state encodings: WAIT_FOR_LOAD, LOADING_ANIM, WAIT_FOR_SHOT, FLYING.
  - macro encodings: BIRD_0..BIRD_2 and NONE = 3'd7.
  - the default of DELTA_MAX.
  - This package is also imported by the bird and top-level blocks.
- One sub-module, aim_axis, is natural. It is instantiated twice and handles one signed saturating up/down axis with clear and capture.
- The FSM and counters stay in the parent.

Test Plan:
- Reset, then 1 tick -> bird_state=1, cnt=0; after 31 further ticks cnt=31; next tick -> bird_state=2, cnt=0.
- In WAIT_FOR_SHOT, hold D and W for 70 ticks -> aim_dx=+63, aim_dy=-63 and both stay there; hold A and D together -> aim_dx unchanged.
- aim_dx=+5, aim_dy=-3, then raise space and press S on the same tick -> launch pulse exactly 1 clk, launch_dx=5, launch_dy=-3, aim outputs 0, bird_state=3.
- Hold space continuously through WAIT_FOR_SHOT entry -> no launch; release, re-press -> launch on the next tick.
- Let FLYING run to completion -> exit on the tick with cnt=480, macro_state 0->1; after three full cycles macro_state=7, birds_done=1, bird_state stays 0.
- Assert rst_n low during FLYING with cnt=200 -> all outputs read 0 asynchronously and launch stays low; on release the sequence restarts from WAIT_FOR_LOAD.
